// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers.
// Issues a registered start pulse with the granted byte and acks the owner on completion.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned BUSY_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] data_i,
  input  logic                    tx_rdy_i,
  output logic                    tx_start_o,
  output logic [DATA_W-1:0]       tx_data_o,
  output logic [N_REQ-1:0]        grant_o,
  output logic [N_REQ-1:0]        ack_o,
  output logic                    err_o,
  output logic                    busy_o,
  output logic [CNT_W-1:0]        sent_count_o
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned TO_W  = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [1:0] {StIdle, StStart, StWaitBusy, StWaitDone} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                start_q, start_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    sent_q, sent_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [TO_W-1:0]     to_inc;
  logic                win_found;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W-1:0]    cand;

  // First requester at or above ptr_q, wrapping modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = PTR_W'((32'(ptr_q) + i) % N_REQ);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign to_inc = to_q + TO_W'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    start_d = 1'b0;
    ack_d   = '0;
    err_d   = 1'b0;
    sent_d  = sent_q;
    to_d    = to_q;
    unique case (state_q)
      StIdle: begin
        if (tx_rdy_i && win_found) begin
          grant_d = '0;
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
              grant_d[i] = 1'b1;
              data_d     = data_i[i*DATA_W +: DATA_W];
            end
          end
          ptr_d   = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
          start_d = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        to_d    = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (!tx_rdy_i) begin
          state_d = StWaitDone;
        end else if (to_inc == TO_W'(BUSY_TIMEOUT - 1)) begin
          // UART never went busy: release the owner with an error, no count.
          ack_d   = grant_q;
          err_d   = 1'b1;
          grant_d = '0;
          state_d = StIdle;
        end else begin
          to_d = to_inc;
        end
      end
      StWaitDone: begin
        if (tx_rdy_i) begin
          ack_d   = grant_q;
          sent_d  = sent_q + CNT_W'(1);
          grant_d = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      sent_q  <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      start_q <= start_d;
      err_q   <= err_d;
      sent_q  <= sent_d;
      to_q    <= to_d;
    end
  end

  assign tx_start_o   = start_q;
  assign tx_data_o    = data_q;
  assign grant_o      = grant_q;
  assign ack_o        = ack_q;
  assign err_o        = err_q;
  assign busy_o       = (state_q != StIdle);
  assign sent_count_o = sent_q;

endmodule
